wave_param_loader: RTL



---
 rtl/wave_param_loader_if.sv | 26 ++
 rtl/wave_param_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wave_param_loader_if.sv
// Host-link byte channel plus the committed parameter bus feeding the two-lane wave compute block.
// Latency: none, wires only.
// Backpressure: rx_valid/rx_ready handshake, and a byte moves only when both are high on a rising edge.
interface wave_param_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] amps;
    logic [31:0] offsets;
    logic [31:0] phasewords;
    logic        active;
    logic        update;
    logic        err;

    // Host / byte front end side.
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, amps, offsets, phasewords, active, update, err
    );

    // Loader side.
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, amps, offsets, phasewords, active, update, err
    );
endinterface

// File: rtl/wave_param_loader.sv
// Decodes host command bytes into shadow amp/offset/phaseword lanes and commits all of them atomically.
// Latency: outputs, active and update change one edge after the commit byte is accepted; err is registered one edge after the bad byte.
// Backpressure: rx_ready is low only during the single COMMIT cycle. Optional feature WAVE_PARAM_LOADER_CHECKSUM_EN adds an XOR check byte.
module wave_param_loader #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] AMP_RESET      = 16'h0000
) (
    input logic           clk,
    input logic           reset,
    wave_param_loader_if.slave bus
);

`ifdef WAVE_PARAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_CHK, S_COMMIT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_COMMIT} state_t;
`endif

    localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

    state_t        r_state, w_state_nxt;
    logic          r_lane;
    logic [1:0]    r_field;
    logic [7:0]    r_hi;
    logic [TW-1:0] r_tcnt;
    logic [31:0]   r_sh_amp, r_sh_off, r_sh_pw;
    logic [31:0]   r_amps, r_offsets, r_phasewords;
    logic          r_active, r_update, r_err;

    logic          w_rdy, w_acc, w_sync_ok, w_in_pkt, w_tmo;
    logic [2:0]    w_op;
    logic          w_err_nxt, w_hdr_ld, w_hi_ld, w_wr_en, w_stop, w_commit;
    logic [15:0]   w_wr_dat;

`ifdef WAVE_PARAM_LOADER_CHECKSUM_EN
    logic [7:0]    r_lo;
    logic          w_lo_ld;
    logic [7:0]    w_csum;
    // The header is rebuilt from the latched lane/field; field ops always have op[2] = 0.
    assign w_csum   = {4'hA, r_lane, 1'b0, r_field} ^ r_hi ^ r_lo;
    assign w_wr_dat = {r_hi, r_lo};
    assign w_in_pkt = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_CHK);
`else
    assign w_wr_dat = {r_hi, bus.rx_data};
    assign w_in_pkt = (r_state == S_HI) || (r_state == S_LO);
`endif

    assign w_rdy     = (r_state != S_COMMIT);
    assign w_acc     = bus.rx_valid && w_rdy;
    assign w_op      = bus.rx_data[2:0];
    assign w_sync_ok = (bus.rx_data[7:4] == 4'hA);
    // Inter-byte gap expires on the edge that would bring the counter to TIMEOUT_CYCLES.
    assign w_tmo     = w_in_pkt && !w_acc && (r_tcnt == TLIM);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_hdr_ld    = 1'b0;
        w_hi_ld     = 1'b0;
        w_wr_en     = 1'b0;
        w_stop      = 1'b0;
        w_commit    = 1'b0;
`ifdef WAVE_PARAM_LOADER_CHECKSUM_EN
        w_lo_ld     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (!w_sync_ok) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        case (w_op)
                            3'b000, 3'b001, 3'b010: begin
                                w_hdr_ld    = 1'b1;
                                w_state_nxt = S_HI;
                            end
                            3'b100:  w_state_nxt = S_COMMIT;
                            3'b101:  w_stop      = 1'b1;
                            default: w_err_nxt   = 1'b1;
                        endcase
                    end
                end
            end
            S_HI: begin
                if (w_acc) begin
                    w_hi_ld     = 1'b1;
                    w_state_nxt = S_LO;
                end else if (w_tmo) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_LO: begin
                if (w_acc) begin
`ifdef WAVE_PARAM_LOADER_CHECKSUM_EN
                    w_lo_ld     = 1'b1;
                    w_state_nxt = S_CHK;
`else
                    w_wr_en     = 1'b1;
                    w_state_nxt = S_IDLE;
`endif
                end else if (w_tmo) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef WAVE_PARAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_acc) begin
                    if (bus.rx_data == w_csum) w_wr_en   = 1'b1;
                    else                       w_err_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Packet context: selected lane/field and the data bytes collected so far.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane  <= 1'b0;
            r_field <= 2'd0;
            r_hi    <= 8'h00;
`ifdef WAVE_PARAM_LOADER_CHECKSUM_EN
            r_lo    <= 8'h00;
`endif
        end else begin
            if (w_hdr_ld) begin
                r_lane  <= bus.rx_data[3];
                r_field <= bus.rx_data[1:0];
            end
            if (w_hi_ld) r_hi <= bus.rx_data;
`ifdef WAVE_PARAM_LOADER_CHECKSUM_EN
            if (w_lo_ld) r_lo <= bus.rx_data;
`endif
        end
    end

    // Inter-byte timeout counter, live only while a field packet is open.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          r_tcnt <= '0;
        else if (w_in_pkt && !w_acc && !w_tmo) r_tcnt <= r_tcnt + TW'(1);
        else                                r_tcnt <= '0;
    end

    // Shadow registers: one 16-bit lane written per completed field packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_amp <= {AMP_RESET, AMP_RESET};
            r_sh_off <= 32'h0;
            r_sh_pw  <= 32'h0;
        end else if (w_wr_en) begin
            case (r_field)
                2'd0: if (r_lane) r_sh_amp[31:16] <= w_wr_dat; else r_sh_amp[15:0] <= w_wr_dat;
                2'd1: if (r_lane) r_sh_off[31:16] <= w_wr_dat; else r_sh_off[15:0] <= w_wr_dat;
                2'd2: if (r_lane) r_sh_pw[31:16]  <= w_wr_dat; else r_sh_pw[15:0]  <= w_wr_dat;
                default: ;
            endcase
        end
    end

    // Committed outputs and status pulses; all 96 shadow bits move on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_amps       <= {AMP_RESET, AMP_RESET};
            r_offsets    <= 32'h0;
            r_phasewords <= 32'h0;
            r_active     <= 1'b0;
            r_update     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_commit) begin
                r_amps       <= r_sh_amp;
                r_offsets    <= r_sh_off;
                r_phasewords <= r_sh_pw;
                r_active     <= 1'b1;
            end else if (w_stop) begin
                r_active     <= 1'b0;
            end
            r_update <= w_commit;
            r_err    <= w_err_nxt;
        end
    end

    assign bus.rx_ready   = w_rdy;
    assign bus.amps       = r_amps;
    assign bus.offsets    = r_offsets;
    assign bus.phasewords = r_phasewords;
    assign bus.active     = r_active;
    assign bus.update     = r_update;
    assign bus.err        = r_err;

endmodule
